// File: rtl/pdp8_trace_buffer.sv
// Trace capture buffer: per-channel holding registers, round-robin arbiter and a
// timestamped show-ahead FIFO drained by the host over a valid/ready port.
module pdp8_trace_buffer #(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned TS_W   = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned REC_W = TS_W + CH_W + 2 + 2 * WORD_W,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        ev_valid,
  input  logic [2*NUM_CH-1:0]      ev_type,
  input  logic [WORD_W*NUM_CH-1:0] ev_addr,
  input  logic [WORD_W*NUM_CH-1:0] ev_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REC_W-1:0]         out_data,
  output logic [AW:0]              count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              drop_count
);

  localparam logic [AW:0]   DepthC   = (AW + 1)'(DEPTH);
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [NUM_CH-1:0] pend_v_q, pend_v_d;
  logic [TS_W-1:0]   pend_ts_q   [NUM_CH];
  logic [1:0]        pend_type_q [NUM_CH];
  logic [WORD_W-1:0] pend_addr_q [NUM_CH];
  logic [WORD_W-1:0] pend_data_q [NUM_CH];

  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [15:0]       drop_q, drop_d;

  logic              pop, push, wr_ok, gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  int unsigned       scan_idx;
  logic [NUM_CH-1:0] gnt_oh, cap, drop;
  logic [16:0]       drop_acc;
  logic [REC_W-1:0]  wr_rec;

  assign out_valid  = (count_q != '0);
  assign out_data   = mem[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == DepthC);
  assign empty      = (count_q == '0);
  assign drop_count = drop_q;

  assign pop   = out_valid && out_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_ok = (count_q < DepthC) || pop;
  assign push  = gnt_found && wr_ok;

  // Round-robin search: first pending channel at or after rr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = int'(rr_q) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!gnt_found && pend_v_q[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(scan_idx);
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    cap      = '0;
    drop     = '0;
    drop_acc = {1'b0, drop_q};
    for (int c = 0; c < NUM_CH; c++) begin
      gnt_oh[c] = push && (gnt_idx == CH_W'(c));
      cap[c]    = enable && !flush && ev_valid[c] && (!pend_v_q[c] || gnt_oh[c]);
      drop[c]   = enable && !flush && ev_valid[c] && pend_v_q[c] && !gnt_oh[c];
      drop_acc  = drop_acc + 17'(drop[c]);
    end
  end

  assign wr_rec = {pend_ts_q[gnt_idx], gnt_idx, pend_type_q[gnt_idx],
                   pend_addr_q[gnt_idx], pend_data_q[gnt_idx]};

  always_comb begin
    ts_d     = enable ? ts_q + TS_W'(1) : ts_q;
    rr_d     = rr_q;
    pend_v_d = pend_v_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_acc[16] ? 16'hFFFF : drop_acc[15:0];
    if (flush) begin
      rr_d     = '0;
      pend_v_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c]) pend_v_d[c] = 1'b1;
        else if (gnt_oh[c]) pend_v_d[c] = 1'b0;
      end
      if (push) begin
        rr_d     = (gnt_idx == LastCh) ? '0 : gnt_idx + CH_W'(1);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      rr_q     <= '0;
      pend_v_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_d;
      rr_q     <= rr_d;
      pend_v_q <= pend_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage carries no reset; validity lives in pend_v_q and count_q.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cap[c]) begin
        pend_ts_q[c]   <= ts_q;
        pend_type_q[c] <= ev_type[2*c +: 2];
        pend_addr_q[c] <= ev_addr[WORD_W*c +: WORD_W];
        pend_data_q[c] <= ev_data[WORD_W*c +: WORD_W];
      end
    end
    if (push && !flush) mem[wr_ptr_q] <= wr_rec;
  end

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
// Scoreboard bench for pdp8_trace_buffer: stimulus pushes expected records, a
// negedge monitor compares every popped head against the queue.
module tb_pdp8_trace_buffer;
  localparam int WORD_W = 12;
  localparam int DEPTH  = 64;
  localparam int NUM_CH = 3;
  localparam int TS_W   = 16;
  localparam int CH_W   = 2;
  localparam int REC_W  = TS_W + CH_W + 2 + 2 * WORD_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic                     flush;
  logic [NUM_CH-1:0]        ev_valid;
  logic [2*NUM_CH-1:0]      ev_type;
  logic [WORD_W*NUM_CH-1:0] ev_addr;
  logic [WORD_W*NUM_CH-1:0] ev_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [REC_W-1:0]         out_data;
  logic [6:0]               count;
  logic                     full;
  logic                     empty;
  logic [15:0]              drop_count;

  pdp8_trace_buffer #(
    .WORD_W(WORD_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .ev_valid(ev_valid), .ev_type(ev_type), .ev_addr(ev_addr), .ev_data(ev_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [REC_W-1:0] exp_q [$];
  logic [REC_W-1:0] mon_exp;
  logic [TS_W-1:0]  m_ts;
  logic [TS_W-1:0]  t_hold;

  // Reference timestamp: cleared by reset only, advances on enabled cycles.
  always @(posedge clk or posedge rst)
    if (rst) m_ts <= '0;
    else if (enable) m_ts <= m_ts + 16'd1;

  function automatic logic [REC_W-1:0] rec(int ts, int ch, int ty, int a, int d);
    return {TS_W'(ts), CH_W'(ch), 2'(ty), WORD_W'(a), WORD_W'(d)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(int ch, int ty, int a, int d);
    ev_valid[ch]           = 1'b1;
    ev_type[2*ch +: 2]     = 2'(ty);
    ev_addr[12*ch +: 12]   = 12'(a);
    ev_data[12*ch +: 12]   = 12'(d);
  endtask

  task automatic clear_ev();
    ev_valid = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(string name);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (empty && exp_q.size() == 0) break;
      tick();
    end
    repeat (3) tick();
    check({name, "_empty"}, 32'(empty), 32'd1);
    check({name, "_records_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_record: got %0h, expected no record", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data === mon_exp) n_pass++;
        else $display("FAIL record: got %0h, expected %0h", out_data, mon_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    ev_valid = '0; ev_type = '0; ev_addr = '0; ev_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // Single event at ts=5 on ch1.
    repeat (5) tick();
    out_ready = 1'b1;
    set_ev(1, 2, 'o0200, 'o7402);
    exp_q.push_back(rec(5, 1, 2, 'o0200, 'o7402));
    tick();
    clear_ev();
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_count", 32'(count), 32'd1);
    tick();
    check("single_count0", 32'(count), 32'd0);

    // Round robin from rr=0, then from rr=1.
    do_flush();
    for (int c = 0; c < NUM_CH; c++) begin
      set_ev(c, c, 'o100 + c, 'o1000 + c);
      exp_q.push_back(rec(m_ts, c, c, 'o100 + c, 'o1000 + c));
    end
    tick();
    clear_ev();
    drain("rr0");
    set_ev(0, 3, 'o11, 'o22);
    exp_q.push_back(rec(m_ts, 0, 3, 'o11, 'o22));
    tick();
    clear_ev();
    drain("rr_single");
    for (int c = 1; c <= NUM_CH; c++) begin
      set_ev(c % NUM_CH, 1, 'o200 + c, 'o2000 + c);
    end
    for (int c = 1; c <= NUM_CH; c++)
      exp_q.push_back(rec(m_ts, c % NUM_CH, 1, 'o200 + c, 'o2000 + c));
    tick();
    clear_ev();
    drain("rr1");

    // Fill to full, one pending, one dropped, then pop with concurrent write.
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_ev(0, 1, i, 'o7000 + i);
      exp_q.push_back(rec(m_ts, 0, 1, i, 'o7000 + i));
      tick();
    end
    clear_ev();
    repeat (2) tick();
    check("full_count", 32'(count), 32'd64);
    check("full_flag", 32'(full), 32'd1);
    set_ev(0, 3, 'o7777, 'o1234);
    exp_q.push_back(rec(m_ts, 0, 3, 'o7777, 'o1234));
    tick();
    set_ev(0, 3, 'o7776, 'o4321);
    tick();
    clear_ev();
    check("full_drop1", 32'(drop_count), 32'd1);
    check("full_hold_count", 32'(count), 32'd64);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pop_count", 32'(count), 32'd64);
    check("full_pop_flag", 32'(full), 32'd1);
    drain("full");
    check("full_drop_after", 32'(drop_count), 32'd1);

    // Drop counter saturation with the FIFO stalled.
    do_flush();
    out_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_ev(c, 0, c, c);
    repeat (23500) tick();
    check("sat_drop", 32'(drop_count), 32'hFFFF);
    repeat (3) tick();
    check("sat_hold", 32'(drop_count), 32'hFFFF);
    check("sat_full", 32'(full), 32'd1);

    // Flush with events still strobing: everything cleared, nothing captured.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_ev();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_drop", 32'(drop_count), 32'd0);
    repeat (3) tick();
    check("flush_no_capture", 32'(count), 32'd0);

    // Disabled: ignored events, frozen timestamp.
    enable = 1'b0;
    t_hold = m_ts;
    tick();
    for (int c = 0; c < NUM_CH; c++) set_ev(c, 2, 5, 6);
    tick();
    clear_ev();
    repeat (3) tick();
    check("dis_count", 32'(count), 32'd0);
    check("dis_drop", 32'(drop_count), 32'd0);
    enable = 1'b1;
    out_ready = 1'b1;
    set_ev(2, 1, 'o55, 'o66);
    exp_q.push_back(rec(t_hold, 2, 1, 'o55, 'o66));
    tick();
    clear_ev();
    drain("dis");

    // Flush of 10 buffered entries; timestamp keeps running.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_ev(2, 2, i, i);
      tick();
    end
    clear_ev();
    repeat (3) tick();
    check("ten_count", 32'(count), 32'd10);
    do_flush();
    check("ten_flush_count", 32'(count), 32'd0);
    check("ten_flush_empty", 32'(empty), 32'd1);
    out_ready = 1'b1;
    set_ev(1, 0, 'o4444, 'o3333);
    exp_q.push_back(rec(m_ts, 1, 0, 'o4444, 'o3333));
    tick();
    clear_ev();
    drain("ts_kept");

    // Asynchronous reset mid-stream with a pending entry.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_ev(0, 1, i, i);
      tick();
    end
    clear_ev();
    repeat (2) tick();
    check("mid_count20", 32'(count), 32'd20);
    set_ev(1, 1, 'o1, 'o2);
    tick();
    clear_ev();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_drop", 32'(drop_count), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check("post_rst_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    set_ev(0, 2, 'o17, 'o27);
    exp_q.push_back(rec(3, 0, 2, 'o17, 'o27));
    tick();
    clear_ev();
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pdp8_trace_buffer.md
# pdp8_trace_buffer

Synthesizable, parametrised trace capture buffer for the PDP-8 emulation platform. It replaces per-event DPI calls with on-chip capture. NUM_CH independent event sources (memory trace, branch trace, register dump, …) post records into per-channel holding registers. A round-robin arbiter moves them into a single timestamped FIFO, which the host transactor drains through a valid/ready port. Lost events are counted rather than silently discarded.

## Interface
Parameters:
- WORD_W, 12, width of address and data fields
- DEPTH, 64, FIFO entries; power of two, ≥ 2
- NUM_CH, 3, number of event channels; ≥ 1
- TS_W, 16, timestamp width

Derived widths:
- CH_W = max(1, clog2(NUM_CH))
- REC_W = TS_W + CH_W + 2 + 2·WORD_W

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  trace armed (driven from CPU run state)
- flush  in  1  synchronous clear of buffered content
- ev_valid  in  NUM_CH  per-channel single-cycle event strobe
- ev_type  in  2·NUM_CH  per-channel record type (channel c at [2c+1:2c])
- ev_addr  in  WORD_W·NUM_CH  per-channel address field
- ev_data  in  WORD_W·NUM_CH  per-channel data field
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head
- out_data  out  REC_W  record = {ts, ch, type, addr, data}, MSB first
- count  out  clog2(DEPTH)+1  FIFO occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop_count  out  16  saturating count of lost events

## Operation
- **Timestamp:** free-running TS_W counter. Increments each cycle while enable=1, holds while enable=0, wraps modulo 2^TS_W.
- **Capture:** when ev_valid[c]=1 and enable=1, the event is latched into pending[c] together with the current timestamp.
  - Capture succeeds if pending[c] is empty, or is being granted in the same cycle.
  - Otherwise the event is dropped and drop_count increments, saturating at 0xFFFF.
- **Disabled capture:** ev_valid while enable=0 is ignored and is not counted as a drop. Already-pending entries still drain.
- **Arbiter:** round-robin pointer rr (reset 0). Each cycle the FIFO can accept a write, it grants the lowest pending index ≥ rr, wrapping to 0. After a grant, rr = (grant+1) mod NUM_CH. At most one grant per cycle.
- **FIFO write condition:** count < DEPTH, or a pop occurs in the same cycle. Full plus a simultaneous pop therefore still accepts a write, and count stays at DEPTH.
- **FIFO read:** show-ahead. out_data shows the head whenever out_valid=1, and a pop occurs when out_valid && out_ready. out_data is don't-care when out_valid=0.
- **Pointers:** read and write pointers are clog2(DEPTH) bits and wrap naturally. Occupancy is tracked in a separate counter.
- **Simultaneous push and pop:** count is unchanged.
- **Flush:** in the cycle after flush=1, the FIFO, all pending registers, rr and drop_count are cleared. The timestamp is not cleared. Events presented in the flush cycle are discarded and not counted.

## Timing
- **Reset values:** out_valid=0, count=0, full=0, empty=1, drop_count=0, timestamp=0, rr=0, all pending empty.
- **Latency:** ev_valid in cycle N → pending at edge N+1 → FIFO at edge N+2 at the earliest → out_valid=1 during cycle N+2. This holds with no contention and with the FIFO not full.
- **Recorded timestamp:** the value of the counter in cycle N (the event cycle), not the grant cycle.
- **Throughput:** 1 record per cycle in and out.
- **Ordering:** within a channel, records are in event order.
- **Backpressure:** with the FIFO full and no pop, grants stall and pending entries hold. A new event on a held channel is dropped.
- **Reset mid-operation:** asynchronous assert clears everything immediately, including in-flight grants. Deassertion is synchronised by the integrating top.

## Test plan
1. **Single event:** reset, enable=1, ch1 event type=2 addr=0o0200 data=0o7402 at ts=5 → out_valid rises 2 cycles later, out_data={5,1,2,0o0200,0o7402}. With out_ready=1, count returns to 0.
2. **Round-robin:** NUM_CH=3, all channels strobe in the same cycle with rr=0 → FIFO order ch0, ch1, ch2, all with identical ts. A repeat after rr=1 yields ch1, ch2, ch0.
3. **Full with pop:** DEPTH=64, out_ready=0, 64 ch0 events spaced one per cycle → full=1, count=64. A 65th event pends, a 66th is dropped (drop_count=1). Raising out_ready for 1 cycle pops one entry and writes the pending one, with count staying 64.
4. **Drop saturation:** force 70000 drops → drop_count=0xFFFF and holds.
5. **Disabled and flush:** enable=0 with an event → no capture, drop_count unchanged, ts holds. Flush with 10 entries buffered → count=0, empty=1, drop_count=0, ts preserved.
6. **Reset mid-stream:** assert rst while count=20 and pending nonzero → all outputs return to reset values asynchronously. The first post-reset event carries ts=0 plus the cycles elapsed since rst fell.
